// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, sign fix-up.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned Steps = XLEN / UNROLL;
  localparam int unsigned CntW  = $clog2(Steps + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(Steps);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic [2*XLEN-1:0]   mc_q, mc_d;    // shifting multiplicand
  logic [XLEN-1:0]     mp_q, mp_d;    // multiplier, or dividend shifting into quotient
  logic [XLEN-1:0]     dv_q, dv_d;    // divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;  // product, or remainder in the low half
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode at accept time
  logic            signed_a_in, signed_b_in, neg_a_in, neg_b_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            b_zero, div_ovf, fast_path;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    signed_a_in = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    signed_b_in = signed_a_in && (funct3 != 3'b010);
    neg_a_in    = signed_a_in && op_a[XLEN-1];
    neg_b_in    = signed_b_in && op_b[XLEN-1];
    mag_a_in    = neg_a_in ? ('0 - op_a) : op_a;
    mag_b_in    = neg_b_in ? ('0 - op_b) : op_b;
    b_zero      = (op_b == '0);
    div_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    fast_path   = funct3[2] && (b_zero || div_ovf);
    if (b_zero) begin
      fast_res = funct3[1] ? op_a : '1;
    end else begin
      fast_res = funct3[1] ? '0 : op_a;
    end
  end

  // UNROLL iterations of the datapath per CALC cycle
  logic [2*XLEN-1:0] mc_n, acc_n;
  logic [XLEN-1:0]   mp_n;
  logic [XLEN:0]     rem_sh, diff;
  logic              is_div, calc_last;

  always_comb begin
    is_div = op_q[2];
    mc_n   = mc_q;
    mp_n   = mp_q;
    acc_n  = acc_q;
    rem_sh = '0;
    diff   = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        rem_sh = {acc_n[XLEN-1:0], mp_n[XLEN-1]};
        diff   = rem_sh - {1'b0, dv_q};
        if (!diff[XLEN]) begin
          acc_n = {{XLEN{1'b0}}, diff[XLEN-1:0]};
          mp_n  = {mp_n[XLEN-2:0], 1'b1};
        end else begin
          acc_n = {{XLEN{1'b0}}, rem_sh[XLEN-1:0]};
          mp_n  = {mp_n[XLEN-2:0], 1'b0};
        end
      end else begin
        if (mp_n[0]) acc_n = acc_n + mc_n;
        mc_n = mc_n << 1;
        mp_n = mp_n >> 1;
      end
    end
`ifdef MULDIV_EARLY_OUT_EN
    calc_last = (cnt_q == 1) || (!is_div && (mp_n == '0));
`else
    calc_last = (cnt_q == 1);
`endif
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? ('0 - acc_q) : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? ('0 - mp_q) : mp_q;
    rem_fix  = sa_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    unique case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    dv_d      = dv_q;
    acc_d     = acc_q;
    result_d  = result_q;
    stall_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d  = funct3;
          sa_d  = neg_a_in;
          sb_d  = neg_b_in;
          mc_d  = {{XLEN{1'b0}}, mag_a_in};
          mp_d  = funct3[2] ? mag_a_in : mag_b_in;
          dv_d  = mag_b_in;
          acc_d = '0;
          cnt_d = CntLoad;
          if (fast_path) begin
            result_d = fast_res;
            state_d  = StDone;
          end else begin
            stall_req = 1'b1;
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        stall_req = 1'b1;
        mc_d      = mc_n;
        mp_d      = mp_n;
        acc_d     = acc_n;
        cnt_d     = cnt_q - 1'b1;
        if (calc_last) state_d = StFix;
      end
      StFix: begin
        stall_req = 1'b1;
        result_d  = fix_res;
        state_d   = StDone;
      end
      default: state_d = StIdle;
    endcase
    // Flush aborts without touching the visible result
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mc_q     <= '0;
      mp_q     <= '0;
      dv_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      dv_q     <= dv_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign done   = (state_q == StDone);
  assign busy   = (state_q != StIdle);
  assign result = result_q;

endmodule
